// File: rtl/e1of2_rx_pkg.sv
// e1of2_rx_pkg: shared types and helpers for the e1of2 synchronous receiver.
//  - rx_state_e   : handshake FSM states
//  - dr_digit_t   : one dual-rail digit {rail1, rail0}
//  - rail0_idx/rail1_idx : position of each rail of digit i in the flat rail bus
//  - dr_decode / dr_valid / dr_illegal : per-digit decode and classification
package e1of2_rx_pkg;

  localparam int DEF_M = 11;

  typedef enum logic [1:0] {
    RST_NEUTRAL  = 2'd0,
    IDLE         = 2'd1,
    WAIT_NEUTRAL = 2'd2
  } rx_state_e;

  typedef struct packed {
    logic r1;
    logic r0;
  } dr_digit_t;

  function automatic int rail0_idx(input int i);
    return 2 * i;
  endfunction

  function automatic int rail1_idx(input int i);
    return 2 * i + 1;
  endfunction

  // Data value of a digit is its rail1; an illegal digit therefore decodes as 1.
  function automatic logic dr_decode(input dr_digit_t d);
    return d.r1;
  endfunction

  // Digit carries data (legal or not).
  function automatic logic dr_valid(input dr_digit_t d);
    return d.r1 | d.r0;
  endfunction

  function automatic logic dr_illegal(input dr_digit_t d);
    return d.r1 & d.r0;
  endfunction

endpackage

// File: rtl/e1of2_sync_receiver_fifo.sv
// sync_fifo: single-clock FIFO with registered head.
//  clk, rst      : clock, asynchronous active-high reset
//  push/push_data: write when !full
//  pop           : consume head when !empty
//  full, empty   : status
//  count         : occupancy, 0..DEPTH
//  head_data     : current head word; stable until popped (storage is flops)
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [W-1:0]             head_data
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic                    do_push, do_pop;

  assign full      = (cnt_q == (AW+1)'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_data = mem_q[rd_q];

  // Guards are redundant with the caller but keep the pointers sane regardless.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = push_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/e1of2_sync_receiver.sv
// e1of2_sync_receiver: clocked receiver for a 4-phase dual-rail (1-of-2 per digit)
// channel. Synchronizes the rails, detects complete/neutral tokens, drives the
// enable back to the sender and queues each decoded token on a valid/ready stream.
//  CLK, RESET  : clock, asynchronous active-high reset
//  in_d        : rails, in_d[2i]=digit i rail0, in_d[2i+1]=digit i rail1
//  in_e        : enable to sender (1 = send data, 0 = return to neutral)
//  out_valid/out_ready/out_data : output stream, out_data bit i = rail1 of digit i
//  fifo_count  : output FIFO occupancy
//  err_illegal : sticky, a captured digit had both rails high
//  err_timeout : sticky, a partial token persisted TIMEOUT cycles while idle
module e1of2_sync_receiver
  import e1of2_rx_pkg::*;
#(
  parameter int M       = DEF_M,
  parameter int DEPTH   = 4,
  parameter int SYNC    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [2*M-1:0]         in_d,
  output logic                   in_e,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [M-1:0]           out_data,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   err_illegal,
  output logic                   err_timeout
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT);

  // ---- synchronizers -------------------------------------------------------
  logic [SYNC-1:0][2*M-1:0] sync_q, sync_d;
  // Marks how far the sync chain has refilled since reset. The reset value of
  // the chain reads as neutral, so neutrality is only believed once real rail
  // samples reach the last stage.
  logic [SYNC-1:0]          vld_pipe_q, vld_pipe_d;
  logic [2*M-1:0]           rails;
  logic                     sync_valid;

  always_comb begin
    sync_d     = {sync_q[SYNC-2:0], in_d};
    vld_pipe_d = {vld_pipe_q[SYNC-2:0], 1'b1};
  end

  assign rails      = sync_q[SYNC-1];
  assign sync_valid = vld_pipe_q[SYNC-1];

  // ---- per-digit detect / decode -------------------------------------------
  logic [M-1:0] word, dig_valid, dig_illegal;

  for (genvar g = 0; g < M; g++) begin : g_digit
    dr_digit_t dig;
    assign dig.r1         = rails[rail1_idx(g)];
    assign dig.r0         = rails[rail0_idx(g)];
    assign word[g]        = dr_decode(dig);
    assign dig_valid[g]   = dr_valid(dig);
    assign dig_illegal[g] = dr_illegal(dig);
  end

  logic complete, neutral, illegal;
  assign complete = &dig_valid;
  assign neutral  = ~|rails;
  assign illegal  = |dig_illegal;

  // ---- FSM, timeout, error flags -------------------------------------------
  rx_state_e       state_q, state_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  logic            err_ill_q, err_ill_d;
  logic            err_to_q, err_to_d;
  logic            push, fifo_full, fifo_empty, pop;

  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    err_ill_d = err_ill_q;
    case (state_q)
      RST_NEUTRAL: if (sync_valid && neutral) state_d = IDLE;
      IDLE: begin
        // With the FIFO full the sender simply keeps holding the token.
        if (complete && !fifo_full) begin
          push    = 1'b1;
          state_d = WAIT_NEUTRAL;
          if (illegal) err_ill_d = 1'b1;
        end
      end
      WAIT_NEUTRAL: if (neutral) state_d = IDLE;
      default: state_d = RST_NEUTRAL;
    endcase
  end

  // Watchdog on partial tokens: only meaningful while waiting for data.
  always_comb begin
    to_cnt_d = '0;
    err_to_d = err_to_q;
    if (state_q == IDLE && !neutral && !complete)
      to_cnt_d = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);
    if (to_cnt_d == TO_MAX) err_to_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sync_q     <= '0;
      vld_pipe_q <= '0;
      state_q    <= RST_NEUTRAL;
      to_cnt_q   <= '0;
      err_ill_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      vld_pipe_q <= vld_pipe_d;
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      err_ill_q  <= err_ill_d;
      err_to_q   <= err_to_d;
    end
  end

  assign in_e        = (state_q == IDLE);
  assign err_illegal = err_ill_q;
  assign err_timeout = err_to_q;

  // ---- output FIFO ---------------------------------------------------------
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  sync_fifo #(
    .W     (M),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RESET),
    .push      (push),
    .push_data (word),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (out_data)
  );

endmodule

// File: tb/tb_e1of2_sync_receiver.sv
module tb_e1of2_sync_receiver;
  localparam int M = 11;
  localparam int DEPTH = 4;

  logic           CLK = 1'b0;
  logic           RESET;
  logic [2*M-1:0] in_d;
  logic           in_e, out_valid, out_ready, err_illegal, err_timeout;
  logic [M-1:0]   out_data;
  logic [2:0]     fifo_count;

  e1of2_sync_receiver #(.M(M), .DEPTH(DEPTH), .SYNC(2), .TIMEOUT(255)) dut (
    .CLK(CLK), .RESET(RESET), .in_d(in_d), .in_e(in_e), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .fifo_count(fifo_count),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int n_rx = 0;
  logic [M-1:0] exp_q[$];
  logic [M-1:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference encoding: digit i carries bit i on rail1, else rail0; an
  // illegal digit raises both. Expected decoded word is rail1 of every digit.
  function automatic logic [2*M-1:0] rails_of(input logic [M-1:0] w, input logic [M-1:0] ill);
    logic [2*M-1:0] r;
    for (int i = 0; i < M; i++) begin
      r[2*i+1] = w[i] | ill[i];
      r[2*i]   = ~w[i] | ill[i];
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_in_e(input logic v, input string name);
    int n = 0;
    while (in_e !== v && n < 200) begin
      tick();
      n++;
    end
    chk(name, {31'd0, in_e}, {31'd0, v});
  endtask

  // Emulated 4-phase sender.
  task automatic send(input logic [M-1:0] w, input logic [M-1:0] ill);
    wait_in_e(1'b1, "send_rdy");
    in_d = rails_of(w, ill);
    exp_q.push_back(w | ill);
    wait_in_e(1'b0, "send_ack");
    in_d = '0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 500) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: a pop happens at the next rising edge whenever valid & ready.
  always @(negedge CLK) begin
    if (!RESET && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (out_data !== mon_exp) begin
          errors++;
          $display("FAIL out_data: got %0h expected %0h", out_data, mon_exp);
        end
      end
      n_rx++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n0;
    logic [2*M-1:0] p;
    bit done;
    RESET = 1'b1; in_d = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_in_e", in_e, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", fifo_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_errs", {err_illegal, err_timeout}, 0);
    RESET = 1'b0;

    // 1: single token, exact handshake latency
    wait_in_e(1'b1, "t1_rdy");
    in_d = rails_of(11'h2A5, '0);
    exp_q.push_back(11'h2A5);
    tick(); tick();
    chk("t1_e_hold", in_e, 1);
    tick();
    chk("t1_e_fall", in_e, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_count", fifo_count, 1);
    chk("t1_data", out_data, 11'h2A5);
    in_d = '0;
    tick(); tick();
    chk("t1_e_low", in_e, 0);
    tick();
    chk("t1_e_rise", in_e, 1);
    drain();

    // 2: streamed tokens
    n0 = n_rx;
    out_ready = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      send(M'(k), '0);
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    chk("t2_nrx", n_rx - n0, 20);
    chk("t2_errs", {err_illegal, err_timeout}, 0);

    // 3: backpressure, fifth token held by sender
    n0 = n_rx;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(M'($urandom), '0);
    wait_in_e(1'b1, "t3_rdy5");
    p = rails_of(11'h7F1, '0);
    in_d = p;
    exp_q.push_back(11'h7F1);
    repeat (10) tick();
    chk("t3_held_e", in_e, 1);
    chk("t3_full", fifo_count, 4);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    wait_in_e(1'b0, "t3_cap5");
    chk("t3_refill", fifo_count, 4);
    in_d = '0;
    drain();
    chk("t3_nrx", n_rx - n0, 5);

    // 4: illegal digit
    out_ready = 1'b0;
    send(11'h001, 11'h008);
    chk("t4_ill", err_illegal, 1);
    chk("t4_to", err_timeout, 0);
    drain();

    // 5: partial token timeout
    wait_in_e(1'b1, "t5_rdy");
    p = '0;
    for (int i = 0; i < 5; i++) p[2*i + ($urandom & 1)] = 1'b1;
    in_d = p;
    repeat (100) tick();
    chk("t5_early", err_timeout, 0);
    repeat (200) tick();
    chk("t5_to", err_timeout, 1);
    chk("t5_in_e", in_e, 1);
    chk("t5_count", fifo_count, 0);
    in_d = '0;
    repeat (5) tick();

    // 6: reset mid-transfer
    out_ready = 1'b0;
    send(11'h111, '0);
    wait_in_e(1'b1, "t6_rdy2");
    in_d = rails_of(11'h222, '0);
    exp_q.push_back(11'h222);
    wait_in_e(1'b0, "t6_cap2");
    chk("t6_q2", fifo_count, 2);
    RESET = 1'b1;
    exp_q.delete();
    tick();
    chk("t6_valid", out_valid, 0);
    chk("t6_count", fifo_count, 0);
    chk("t6_in_e", in_e, 0);
    chk("t6_errs", {err_illegal, err_timeout}, 0);
    RESET = 1'b0;
    repeat (10) tick();
    chk("t6_hold_e", in_e, 0);
    in_d = '0;
    wait_in_e(1'b1, "t6_rise");
    out_ready = 1'b1;
    n0 = n_rx;
    send(11'h5A3, '0);
    drain();
    chk("t6_nrx", n_rx - n0, 1);

    // 7: random tokens with random consumer
    n0 = n_rx;
    done = 1'b0;
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          send(M'($urandom), '0);
          repeat ($urandom_range(0, 3)) tick();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
      end
    join
    drain();
    chk("t7_nrx", n_rx - n0, 30);
    chk("t7_ill", err_illegal, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
